// File: rtl/cnt_seq_pkg.sv
// Shared definitions for the 2-bit counter sequencer: state encodings, FSM
// states, the counter transition function and the shortest-path x selector.
package cnt_seq_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

    // Width of the hold counter (HOLD_CYCLES up to 15)
    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } fsm_t;

    // Counter next state: x=0 always lands in 01, x=1 walks 00/01->10->11->00
    function automatic logic [1:0] cnt_nxt(input logic [1:0] s, input logic x);
        logic [1:0] n;
        if (!x) begin
            n = S01;
        end else begin
            case (s)
                S00:     n = S10;
                S01:     n = S10;
                S10:     n = S11;
                default: n = S00;
            endcase
        end
        return n;
    endfunction

    // x that starts the shortest walk from cur to tgt
    function automatic logic cnt_path_x(input logic [1:0] cur, input logic [1:0] tgt);
        logic x;
        case (tgt)
            S01:     x = 1'b0;
            S10:     x = (cur != S11);
            default: x = 1'b1;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/cnt_seq_arbiter_rr.sv
// cnt_rr_arb: N_REQ-wide winner select for the counter sequencer.
// Default: round-robin, search starts at the registered pointer, which moves
// to (served index + 1) mod N_REQ when adv pulses.
// CNT_SEQ_FIXED_PRIO_EN: fixed priority, lowest index wins, no pointer.
// Ports: clk, rst_n, req[N_REQ], adv (served pulse), adv_idx (served index),
//        win_vld_c / win_idx_c (combinational winner).
module cnt_rr_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             adv,
    input  logic [IDX_W-1:0] adv_idx,
    output logic             win_vld_c,
    output logic [IDX_W-1:0] win_idx_c
);

`ifdef CNT_SEQ_FIXED_PRIO_EN

    // Lowest set index wins; scan downward so the last hit is the lowest
    always_comb begin
        win_vld_c = 1'b0;
        win_idx_c = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld_c = 1'b1;
                win_idx_c = IDX_W'(i);
            end
        end
    end

    logic unused_c;
    assign unused_c = ^{clk, rst_n, adv, adv_idx};

`else

    logic [IDX_W-1:0] ptr_q;

    // Pointer holds the first index to search on the next arbitration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (adv) begin
            ptr_q <= (adv_idx == IDX_W'(N_REQ - 1)) ? '0 : adv_idx + IDX_W'(1);
        end
    end

    // First requester found walking up from the pointer, wrapping
    always_comb begin
        logic [IDX_W-1:0] idx;
        win_vld_c = 1'b0;
        win_idx_c = '0;
        idx       = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = IDX_W'((32'(ptr_q) + off) % N_REQ);
            if (!win_vld_c && req[idx]) begin
                win_vld_c = 1'b1;
                win_idx_c = idx;
            end
        end
    end

`endif

endmodule

// File: rtl/cnt_seq_arbiter.sv
// cnt_seq_arbiter: grants one requester at a time, walks the 2-bit counter
// to that requester's target along the shortest path, holds for HOLD_CYCLES,
// then pulses done. Keeps a shadow of the counter state.
// Ports: clk, rst_n, req[N_REQ], tgt[2*N_REQ] (2 bits per requester),
//        gnt[N_REQ], done[N_REQ], x_out, step_en, cur_state[2], busy.
// Macro CNT_SEQ_FIXED_PRIO_EN selects fixed-priority arbitration.
module cnt_seq_arbiter
    import cnt_seq_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] tgt,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               x_out,
    output logic               step_en,
    output logic [1:0]         cur_state,
    output logic               busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    fsm_t              state_q, state_d;
    logic [1:0]        target_q, target_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        cur_d;
    logic [N_REQ-1:0]  gnt_d, done_d;
    logic              x_d, step_d, busy_d;
    logic              arb_vld_c;
    logic [IDX_W-1:0]  arb_idx_c;
    logic              adv_c;

    cnt_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .adv       (adv_c),
        .adv_idx   (win_q),
        .win_vld_c (arb_vld_c),
        .win_idx_c (arb_idx_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= S00;
            win_q     <= '0;
            hold_q    <= '0;
            cur_state <= S00;
            gnt       <= '0;
            done      <= '0;
            x_out     <= 1'b0;
            step_en   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            win_q     <= win_d;
            hold_q    <= hold_d;
            cur_state <= cur_d;
            gnt       <= gnt_d;
            done      <= done_d;
            x_out     <= x_d;
            step_en   <= step_d;
            busy      <= busy_d;
        end
    end

    // Next state; outputs are decoded from the next state so they line up
    // with the state they belong to
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        win_d    = win_q;
        hold_d   = hold_q;
        adv_c    = 1'b0;
        cur_d    = step_en ? cnt_nxt(cur_state, x_out) : cur_state;

        case (state_q)
            IDLE: begin
                if (arb_vld_c) begin
                    win_d    = arb_idx_c;
                    target_d = tgt[{arb_idx_c, 1'b0} +: 2];
                    if (cur_state != target_d) begin
                        state_d = STEP;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HOLD_W'(HOLD_CYCLES);
                    end
                end
            end
            STEP: begin
                if (cnt_nxt(cur_state, x_out) == target_q) begin
                    state_d = HOLD;
                    hold_d  = HOLD_W'(HOLD_CYCLES);
                end
            end
            HOLD: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q == HOLD_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                adv_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        step_d = (state_d == STEP);
        x_d    = (state_d == STEP) ? cnt_path_x(cur_d, target_d) : 1'b0;
        busy_d = (state_d != IDLE);
        gnt_d  = (state_d != IDLE) ? (N_REQ'(1) << win_d) : '0;
        done_d = (state_d == DONE) ? (N_REQ'(1) << win_d) : '0;
    end

endmodule

// File: tb/tb_cnt_seq_arbiter.sv
// Self-checking bench for cnt_seq_arbiter: directed vector table, reset
// corner case, then randomized transactions against a reference model that
// finds the shortest x sequence by search over the counter transition table.
module tb_cnt_seq_arbiter;

    localparam int unsigned N_REQ       = 4;
    localparam int unsigned HOLD_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] tgt;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       x_out;
    logic       step_en;
    logic [1:0] cur_state;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    int         m_ptr = 0;
    logic [1:0] m_cur = 2'b00;
    logic [1:0] nxt_tbl [4][2];

    typedef struct {
        logic [3:0] req;
        logic [7:0] tgt;
        int         win;
        int         steps;
        logic [2:0] xs;
        int         dcyc;
    } vec_t;

    vec_t vecs [9];

    cnt_seq_arbiter #(
        .N_REQ       (N_REQ),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .tgt       (tgt),
        .gnt       (gnt),
        .done      (done),
        .x_out     (x_out),
        .step_en   (step_en),
        .cur_state (cur_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [3:0] r);
`ifdef CNT_SEQ_FIXED_PRIO_EN
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (r[i]) return i;
        end
`else
        for (int off = 0; off < int'(N_REQ); off++) begin
            int i;
            i = (m_ptr + off) % int'(N_REQ);
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    // Shortest x sequence from 'from' to 'to'; ties resolved with x=0 first
    task automatic model_path(input logic [1:0] from, input logic [1:0] to,
                              output int n, output logic [2:0] xs);
        n  = -1;
        xs = '0;
        for (int len = 0; len <= 3 && n < 0; len++) begin
            for (int pat = 0; pat < (1 << len) && n < 0; pat++) begin
                logic [1:0] s;
                logic [2:0] b;
                s = from;
                b = '0;
                for (int k = 0; k < len; k++) begin
                    b[k] = pat[len - 1 - k];
                    s    = nxt_tbl[s][b[k]];
                end
                if (s == to) begin
                    n  = len;
                    xs = b;
                end
            end
        end
    endtask

    // Apply req/tgt before an acceptance edge and check every cycle up to
    // the IDLE cycle after done. Returns 1 ns after that IDLE cycle's edge.
    task automatic do_txn(input string tag, input logic [3:0] r, input logic [7:0] t,
                          input int win, input int steps, input logic [2:0] xs,
                          input int dcyc, input bit perturb);
        logic [3:0] oh;
        logic [1:0] target;
        oh     = 4'(1 << win);
        target = t[2*win +: 2];
        req    = r;
        tgt    = t;
        tick();
        if (perturb) begin
            req = 4'($urandom);
            tgt = 8'($urandom);
        end
        for (int c = 1; c <= dcyc; c++) begin
            chk({tag, " gnt"}, int'(gnt), int'(oh));
            chk({tag, " busy"}, int'(busy), 1);
            chk({tag, " done"}, int'(done), (c == dcyc) ? int'(oh) : 0);
            chk({tag, " step_en"}, int'(step_en), (c <= steps) ? 1 : 0);
            chk({tag, " x_out"}, int'(x_out), (c <= steps) ? int'(xs[c-1]) : 0);
            if (c == steps + 1) chk({tag, " cur_state"}, int'(cur_state), int'(target));
            if (c < dcyc) tick();
        end
        tick();
        chk({tag, " idle gnt"}, int'(gnt), 0);
        chk({tag, " idle busy"}, int'(busy), 0);
        chk({tag, " idle done"}, int'(done), 0);
        chk({tag, " idle step_en"}, int'(step_en), 0);
        m_cur = target;
        m_ptr = (win + 1) % int'(N_REQ);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " gnt"}, int'(gnt), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " x_out"}, int'(x_out), 0);
        chk({tag, " step_en"}, int'(step_en), 0);
        chk({tag, " cur_state"}, int'(cur_state), 0);
        chk({tag, " busy"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        logic [2:0] xs;
        logic [3:0] r;
        logic [7:0] t;
        int         w;
        logic [7:0] t_rst;

        nxt_tbl[0][0] = 2'b01; nxt_tbl[0][1] = 2'b10;
        nxt_tbl[1][0] = 2'b01; nxt_tbl[1][1] = 2'b10;
        nxt_tbl[2][0] = 2'b01; nxt_tbl[2][1] = 2'b11;
        nxt_tbl[3][0] = 2'b01; nxt_tbl[3][1] = 2'b00;

        vecs[0] = '{4'b0100, 8'h10, 2, 1, 3'b000, 4};
        vecs[1] = '{4'b0001, 8'h00, 0, 3, 3'b111, 6};
        vecs[2] = '{4'b0010, 8'h00, 1, 0, 3'b000, 3};
        vecs[3] = '{4'b0010, 8'h0C, 1, 2, 3'b011, 5};
        vecs[4] = '{4'b1000, 8'h80, 3, 2, 3'b010, 5};
        vecs[5] = '{4'b1011, 8'hFF, 0, 1, 3'b001, 4};
`ifdef CNT_SEQ_FIXED_PRIO_EN
        vecs[6] = '{4'b1011, 8'hFF, 0, 0, 3'b000, 3};
        vecs[7] = '{4'b1011, 8'hFF, 0, 0, 3'b000, 3};
`else
        vecs[6] = '{4'b1011, 8'hFF, 1, 0, 3'b000, 3};
        vecs[7] = '{4'b1011, 8'hFF, 3, 0, 3'b000, 3};
`endif
        vecs[8] = '{4'b1011, 8'hFF, 0, 0, 3'b000, 3};

        rst_n = 1'b0;
        req   = '0;
        tgt   = '0;
        #1;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].tgt, vecs[i].win,
                   vecs[i].steps, vecs[i].xs, vecs[i].dcyc, 1'b0);
        end

        // Reset during STEP: cur=11, tgt0=10 takes two steps
        t_rst = 8'b00_00_00_10;
        req   = 4'b0001;
        tgt   = t_rst;
        tick();
        chk("rst_mid step_en", int'(step_en), 1);
        chk("rst_mid x_out", int'(x_out), 0);
        chk("rst_mid gnt", int'(gnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid async");
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        m_cur = 2'b00;
        do_txn("rst_rearb", 4'b0001, t_rst, 0, 1, 3'b001, 4, 1'b0);

        for (int it = 0; it < 60; it++) begin
            r = 4'($urandom_range(0, 15));
            t = 8'($urandom);
            if (r == 4'b0000) begin
                req = r;
                tgt = t;
                tick();
                chk("rand noreq busy", int'(busy), 0);
                chk("rand noreq gnt", int'(gnt), 0);
            end else begin
                w = model_pick(r);
                model_path(m_cur, t[2*w +: 2], n, xs);
                do_txn($sformatf("rand%0d", it), r, t, w, n, xs,
                       n + int'(HOLD_CYCLES) + 1, 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
